// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
// alarm_scheduler : multi-slot BCD alarm with beep cadence, ring timeout,
//                   snooze (BCD wrap past midnight) and dismiss.
// Revision        : 1.0
// ============================================================================
module alarm_scheduler #(
    parameter  int N_ALARMS   = 4,
    parameter  int RING_SEC   = 60,
    parameter  int SNOOZE_MIN = 5,
    parameter  int BEEP_ON    = 1,
    parameter  int BEEP_OFF   = 1,
    localparam int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sec_tick_i,
    input  logic [3:0]          hourdec_now_i,
    input  logic [3:0]          hourone_now_i,
    input  logic [3:0]          mindec_now_i,
    input  logic [3:0]          minone_now_i,
    input  logic                cfg_we_i,
    input  logic [IDX_W-1:0]    cfg_idx_i,
    input  logic [15:0]         cfg_time_i,
    input  logic                cfg_en_i,
    input  logic                snooze_i,
    input  logic                dismiss_i,
    output logic                aud_en_o,
    output logic                ringing_o,
    output logic                snoozed_o,
    output logic [IDX_W-1:0]    active_idx_o,
    output logic [N_ALARMS-1:0] slot_en_o
);

    localparam int         SEC_W      = $clog2(RING_SEC + 1);
    localparam int         c_CAD_MAX  = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int         CAD_W      = $clog2(c_CAD_MAX + 1);
    localparam logic [SEC_W-1:0] c_SEC_LAST = SEC_W'(RING_SEC - 1);
    localparam logic [CAD_W-1:0] c_ON_LAST  = CAD_W'(BEEP_ON - 1);
    localparam logic [CAD_W-1:0] c_OFF_LAST = CAD_W'(BEEP_OFF - 1);
    localparam logic [3:0] c_SNZ_TENS = 4'(SNOOZE_MIN / 10);
    localparam logic [3:0] c_SNZ_ONES = 4'(SNOOZE_MIN % 10);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } state_t;

    state_t            state_q;
    logic [15:0]       prev_q;
    logic              prev_valid_q;
    logic [15:0]       slot_time_q [N_ALARMS];
    logic [N_ALARMS-1:0] slot_en_q;
    logic [IDX_W-1:0]  active_idx_q;
    logic              aud_en_q;
    logic              ringing_q;
    logic              snoozed_q;
    logic [SEC_W-1:0]  sec_cnt_q;
    logic [CAD_W-1:0]  cad_cnt_q;
    logic [15:0]       target_q;

    logic [15:0]       w_now;
    logic              w_edge;
    logic              w_kill;
    logic              w_win_valid;
    logic [IDX_W-1:0]  w_win_idx;
    logic [4:0]        w_mo_sum, w_md_sum;
    logic              w_mo_c, w_md_c;
    logic [3:0]        w_t_hd, w_t_ho, w_t_md, w_t_mo;
    logic [15:0]       w_target;

    assign w_now  = {hourdec_now_i, hourone_now_i, mindec_now_i, minone_now_i};
    assign w_edge = prev_valid_q && (w_now != prev_q);
    assign w_kill = cfg_we_i && !cfg_en_i && (cfg_idx_i == active_idx_q);

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (w_edge && slot_en_q[i] && (slot_time_q[i] == w_now)) begin
                w_win_valid = 1'b1;
                w_win_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_mo_sum = {1'b0, minone_now_i} + {1'b0, c_SNZ_ONES};
        w_mo_c   = (w_mo_sum >= 5'd10);
        w_t_mo   = w_mo_c ? 4'(w_mo_sum - 5'd10) : w_mo_sum[3:0];
        w_md_sum = {1'b0, mindec_now_i} + {1'b0, c_SNZ_TENS} + {4'b0000, w_mo_c};
        w_md_c   = (w_md_sum >= 5'd6);
        w_t_md   = w_md_c ? 4'(w_md_sum - 5'd6) : w_md_sum[3:0];
        w_t_hd   = hourdec_now_i;
        w_t_ho   = hourone_now_i;
        if (w_md_c) begin
            if (hourdec_now_i == 4'd2 && hourone_now_i == 4'd3) begin
                w_t_hd = 4'd0;
                w_t_ho = 4'd0;
            end else if (hourone_now_i == 4'd9) begin
                w_t_hd = hourdec_now_i + 4'd1;
                w_t_ho = 4'd0;
            end else begin
                w_t_ho = hourone_now_i + 4'd1;
            end
        end
    end
    assign w_target = {w_t_hd, w_t_ho, w_t_md, w_t_mo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            slot_en_q    <= '0;
            for (int i = 0; i < N_ALARMS; i++) slot_time_q[i] <= '0;
            active_idx_q <= '0;
            aud_en_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozed_q    <= 1'b0;
            sec_cnt_q    <= '0;
            cad_cnt_q    <= '0;
            target_q     <= '0;
        end else begin
            prev_q       <= w_now;
            prev_valid_q <= 1'b1;
            if (cfg_we_i && (int'(cfg_idx_i) < N_ALARMS)) begin
                slot_time_q[cfg_idx_i] <= cfg_time_i;
                slot_en_q[cfg_idx_i]   <= cfg_en_i;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_win_valid) begin
                        state_q      <= S_RING;
                        active_idx_q <= w_win_idx;
                        aud_en_q     <= 1'b1;
                        ringing_q    <= 1'b1;
                        sec_cnt_q    <= '0;
                        cad_cnt_q    <= '0;
                    end
                end
                S_RING: begin
                    if (dismiss_i || w_kill) begin
                        state_q   <= S_IDLE;
                        aud_en_q  <= 1'b0;
                        ringing_q <= 1'b0;
                    end else if (snooze_i) begin
                        state_q   <= S_SNOOZE;
                        aud_en_q  <= 1'b0;
                        ringing_q <= 1'b0;
                        snoozed_q <= 1'b1;
                        target_q  <= w_target;
                    end else if (sec_tick_i) begin
                        if (sec_cnt_q == c_SEC_LAST) begin
                            state_q   <= S_IDLE;
                            aud_en_q  <= 1'b0;
                            ringing_q <= 1'b0;
                        end else begin
                            sec_cnt_q <= sec_cnt_q + 1'b1;
                            if (cad_cnt_q == (aud_en_q ? c_ON_LAST : c_OFF_LAST)) begin
                                aud_en_q  <= !aud_en_q;
                                cad_cnt_q <= '0;
                            end else begin
                                cad_cnt_q <= cad_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                S_SNOOZE: begin
                    if (dismiss_i || w_kill) begin
                        state_q   <= S_IDLE;
                        snoozed_q <= 1'b0;
                    end else if (w_edge && (w_now == target_q)) begin
                        // A tick landing on re-entry counts as the first second of the new ring.
                        state_q   <= S_RING;
                        ringing_q <= 1'b1;
                        snoozed_q <= 1'b0;
                        sec_cnt_q <= sec_tick_i ? SEC_W'(1) : '0;
                        if (sec_tick_i && (BEEP_ON == 1)) begin
                            aud_en_q  <= 1'b0;
                            cad_cnt_q <= '0;
                        end else begin
                            aud_en_q  <= 1'b1;
                            cad_cnt_q <= sec_tick_i ? CAD_W'(1) : '0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign aud_en_o     = aud_en_q;
    assign ringing_o    = ringing_q;
    assign snoozed_o    = snoozed_q;
    assign active_idx_o = active_idx_q;
    assign slot_en_o    = slot_en_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_scheduler.sv
`default_nettype none
// tb_alarm_scheduler : directed scenarios for alarm_scheduler against a minute-of-day reference model.
module tb_alarm_scheduler;
    localparam int N          = 4;
    localparam int RING_SEC   = 60;
    localparam int SNOOZE_MIN = 5;
    localparam int BEEP_ON    = 1;
    localparam int BEEP_OFF   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sec_tick = 1'b0;
    logic [3:0]  hd = 4'd0, ho = 4'd0, md = 4'd0, mo = 4'd0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = 2'd0;
    logic [15:0] cfg_time = 16'h0000;
    logic        cfg_en = 1'b0;
    logic        snooze = 1'b0;
    logic        dismiss = 1'b0;
    logic        aud_en, ringing, snoozed;
    logic [1:0]  active_idx;
    logic [N-1:0] slot_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alarm_scheduler #(
        .N_ALARMS(N), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN),
        .BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF)
    ) dut (
        .clk(clk), .rst(rst), .sec_tick_i(sec_tick),
        .hourdec_now_i(hd), .hourone_now_i(ho), .mindec_now_i(md), .minone_now_i(mo),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_time_i(cfg_time), .cfg_en_i(cfg_en),
        .snooze_i(snooze), .dismiss_i(dismiss),
        .aud_en_o(aud_en), .ringing_o(ringing), .snoozed_o(snoozed),
        .active_idx_o(active_idx), .slot_en_o(slot_en)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_min(input logic [15:0] t);
        return (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    // Reference model: mode 0 idle, 1 ring, 2 snooze; times as minutes of the day.
    int m_mode = 0, m_idx = 0, m_ticks = 0, m_target = 0, m_prev = 0;
    bit m_pv = 1'b0;
    int slot_min [N];
    bit slot_on  [N];

    always @(posedge clk) begin : model
        int now_m, win;
        bit edg, kill, exp_aud;
        logic [N-1:0] exp_en;
        if (rst) begin
            m_mode = 0; m_idx = 0; m_ticks = 0; m_target = 0; m_prev = 0; m_pv = 1'b0;
            for (int i = 0; i < N; i++) begin slot_min[i] = 0; slot_on[i] = 1'b0; end
        end else begin
            now_m = to_min({hd, ho, md, mo});
            edg   = m_pv && (now_m != m_prev);
            win   = -1;
            for (int i = 0; i < N; i++)
                if (edg && slot_on[i] && slot_min[i] == now_m && win < 0) win = i;
            kill = cfg_we && !cfg_en && (int'(cfg_idx) == m_idx);
            case (m_mode)
                0: if (win >= 0) begin m_mode = 1; m_idx = win; m_ticks = 0; end
                1: begin
                    if (dismiss || kill) m_mode = 0;
                    else if (snooze) begin m_mode = 2; m_target = (now_m + SNOOZE_MIN) % 1440; end
                    else if (sec_tick) begin
                        m_ticks++;
                        if (m_ticks >= RING_SEC) m_mode = 0;
                    end
                end
                default: begin
                    if (dismiss || kill) m_mode = 0;
                    else if (edg && now_m == m_target) begin m_mode = 1; m_ticks = sec_tick ? 1 : 0; end
                end
            endcase
            if (cfg_we) begin slot_min[cfg_idx] = to_min(cfg_time); slot_on[cfg_idx] = cfg_en; end
            m_prev = now_m;
            m_pv   = 1'b1;
        end
        #1;
        exp_aud = (m_mode == 1) && ((m_ticks % (BEEP_ON + BEEP_OFF)) < BEEP_ON);
        for (int i = 0; i < N; i++) exp_en[i] = slot_on[i];
        check("cyc_ringing", 32'(ringing), 32'(m_mode == 1));
        check("cyc_snoozed", 32'(snoozed), 32'(m_mode == 2));
        check("cyc_aud_en", 32'(aud_en), 32'(exp_aud));
        check("cyc_active_idx", 32'(active_idx), 32'(m_idx));
        check("cyc_slot_en", 32'(slot_en), 32'(exp_en));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_now(input logic [15:0] t);
        {hd, ho, md, mo} = t;
    endtask

    task automatic write_slot(input logic [1:0] i, input logic [15:0] t, input logic e);
        cfg_we = 1'b1; cfg_idx = i; cfg_time = t; cfg_en = e;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic t, input logic s, input logic d);
        sec_tick = t; snooze = s; dismiss = d;
        cyc(1);
        sec_tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    endtask

    logic [15:0] gap [4] = '{16'h2359, 16'h0000, 16'h0001, 16'h0002};

    initial begin
        cyc(2);
        check("rst_aud", 32'(aud_en), 32'd0);
        check("rst_ringing", 32'(ringing), 32'd0);
        check("rst_active", 32'(active_idx), 32'd0);
        check("rst_slot_en", 32'(slot_en), 32'd0);
        rst = 1'b0;

        // Single alarm, cadence and timeout
        set_now(16'h0729);
        write_slot(2'd1, 16'h0730, 1'b1);
        cyc(2);
        check("t1_slot_en", 32'(slot_en), 32'h2);
        set_now(16'h0730);
        cyc(1);
        check("t1_ringing", 32'(ringing), 32'd1);
        check("t1_active", 32'(active_idx), 32'd1);
        check("t1_aud_entry", 32'(aud_en), 32'd1);
        pulse(1'b1, 1'b0, 1'b0);
        check("t1_aud_tick1", 32'(aud_en), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check("t1_aud_tick2", 32'(aud_en), 32'd1);
        for (int k = 2; k < 59; k++) begin
            pulse(1'b1, 1'b0, 1'b0);
            cyc(1);
        end
        check("t1_ring_59", 32'(ringing), 32'd1);
        pulse(1'b1, 1'b0, 1'b0);
        check("t1_timeout_ring", 32'(ringing), 32'd0);
        check("t1_timeout_aud", 32'(aud_en), 32'd0);

        // Simultaneous match, lowest slot wins
        set_now(16'h1159);
        write_slot(2'd0, 16'h1200, 1'b1);
        write_slot(2'd2, 16'h1200, 1'b1);
        cyc(1);
        set_now(16'h1200);
        cyc(1);
        check("t2_active", 32'(active_idx), 32'd0);
        check("t2_ringing", 32'(ringing), 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        check("t2_dismiss", 32'(ringing), 32'd0);
        cyc(3);
        check("t2_no_refire", 32'(ringing), 32'd0);
        pulse(1'b0, 1'b1, 1'b0);
        check("t2_idle_snooze", 32'(snoozed), 32'd0);

        // Snooze across midnight
        write_slot(2'd0, 16'h2358, 1'b1);
        set_now(16'h2357);
        cyc(2);
        set_now(16'h2358);
        cyc(1);
        check("t3_ringing", 32'(ringing), 32'd1);
        cyc(1);
        pulse(1'b0, 1'b1, 1'b0);
        check("t3_snoozed", 32'(snoozed), 32'd1);
        check("t3_snz_aud", 32'(aud_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_now(gap[i]);
            cyc(2);
            check("t3_gap_quiet", 32'(ringing), 32'd0);
        end
        set_now(16'h0003);
        pulse(1'b1, 1'b0, 1'b0);
        check("t3_rering", 32'(ringing), 32'd1);
        check("t3_rering_idx", 32'(active_idx), 32'd0);
        check("t3_tick_consumed", 32'(aud_en), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check("t3_aud_back", 32'(aud_en), 32'd1);
        pulse(1'b0, 1'b0, 1'b1);

        // Snooze and dismiss together
        set_now(16'h2357);
        cyc(2);
        set_now(16'h2358);
        cyc(1);
        pulse(1'b0, 1'b1, 1'b1);
        check("t4_ringing", 32'(ringing), 32'd0);
        check("t4_snoozed", 32'(snoozed), 32'd0);

        // Reconfiguring the active slot while ringing
        set_now(16'h0459);
        write_slot(2'd3, 16'h0500, 1'b1);
        cyc(1);
        set_now(16'h0500);
        cyc(1);
        check("t5_active", 32'(active_idx), 32'd3);
        write_slot(2'd3, 16'h0600, 1'b1);
        check("t5_keep_ring", 32'(ringing), 32'd1);
        write_slot(2'd3, 16'h0600, 1'b0);
        check("t5_kill_ring", 32'(ringing), 32'd0);
        check("t5_slot_en", 32'(slot_en), 32'h7);

        // Asynchronous reset mid-ring
        set_now(16'h0729);
        cyc(2);
        set_now(16'h0730);
        cyc(1);
        check("t6_ringing", 32'(ringing), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_aud", 32'(aud_en), 32'd0);
        check("t6_async_ring", 32'(ringing), 32'd0);
        check("t6_async_slots", 32'(slot_en), 32'd0);
        @(negedge clk);
        cyc(1);
        rst = 1'b0;
        write_slot(2'd1, 16'h0730, 1'b1);
        cyc(3);
        check("t6_no_first_ring", 32'(ringing), 32'd0);
        set_now(16'h0731);
        cyc(1);
        set_now(16'h0730);
        cyc(1);
        check("t6_ring_again", 32'(ringing), 32'd1);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
